seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one seven_seg_decoder across NUM_DIGITS common-cathode digits. It accepts a packed BCD word through a valid/ready handshake and holds it in a pending buffer. The word is committed to a shadow register only at frame boundaries, so the display never tears. Each digit is strobed in turn, with a blanking gap between digits to suppress ghosting. The block sits between the register/control logic and the display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
TICK_DIV, 1000, clk cycles per scan tick (>=2)
ON_TICKS, 4, ticks a digit is driven per slot (>=1)
BLANK_TICKS, 1, ticks all digits are off between slots (>=1)
LZ_BLANK, 1, 1 = suppress leading zeros (digit 0 always shown)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  1 = scanning; 0 = display off
wr_valid  in  1  new display word offered
wr_data  in  4*NUM_DIGITS  packed BCD; digit i = wr_data[4i+3:4i], digit 0 = least significant
wr_ready  out  1  pending buffer empty, word will be accepted
digit_en  out  NUM_DIGITS  one-hot digit strobe, active-high
seg  out  7  segment drive from the shared decoder; 7'b0000000 = all off
frame_done  out  1  one-cycle pulse when a frame completes
bcd_err  out  1  sticky; set when an accepted word holds a nibble >9; cleared by reset

Behaviour:
- Reset values (rst sampled high on a clk edge): state=IDLE, prescaler=0, idx=0, tick count=0, shadow=0, pending empty, wr_ready=1, digit_en=0, seg=0, frame_done=0, bcd_err=0. Reset mid-frame aborts the scan immediately and discards the pending word.
- Prescaler: counts 0..TICK_DIV-1 only while state!=IDLE. tick=1 on the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- Handshake: a transfer occurs on a cycle where wr_valid&&wr_ready. The word is copied into pending and wr_ready drops on the next cycle. bcd_err is set on the same edge if any nibble >9.
- Commit: a pending word is copied into shadow on the edge where the state enters SHOW with idx=0, including the IDLE->SHOW transition. pending then empties and wr_ready rises on the following cycle.
- Commit vs. transfer: if a commit and a transfer coincide, it is impossible, because a transfer requires pending to be empty. One word per frame is committed at most.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE: digit_en=0. When enable=1, go to SHOW with idx=0 and the prescaler cleared.
  - SHOW: digit_en[idx]=1. After ON_TICKS ticks, go to BLANK.
  - BLANK: digit_en=0. After BLANK_TICKS ticks:
    - if idx==NUM_DIGITS-1: pulse frame_done on the last BLANK cycle, set idx=0, go to SHOW;
    - otherwise idx+=1 and go to SHOW.
- enable=0 in any state: go to IDLE on the next edge. digit_en=0 from that edge. idx, tick count and prescaler are reset. shadow and pending are held.
- Outputs: digit_en and the decoder input bin=shadow[4*idx+:4] are registered and change on the same edge. seg is the combinational decoder output of registered bin, gated to 0 whenever digit_en==0.
- Leading-zero blanking: with LZ_BLANK=1, digit i>0 is blanked (digit_en stays 0 for its SHOW slot; timing unchanged) if it and every higher digit are zero.
- Nibble >9: seg=0 for that slot; the digit strobe is still asserted.
- Frame length = NUM_DIGITS*(ON_TICKS+BLANK_TICKS)*TICK_DIV cycles.

Decomposition:
- Shared package seven_seg_pkg:
  - SEG_OFF = 7'b0000000
  - state encoding (IDLE=2'd0, SHOW=2'd1, BLANK=2'd2)
  - BCD_MAX=4'd9
- Sub-modules:
  - one instance of the existing seven_seg_decoder (bin/seg);
  - prescaler kept inline.

Test Plan:
(All scenarios use NUM_DIGITS=4, TICK_DIV=4, ON_TICKS=2, BLANK_TICKS=1, LZ_BLANK=0 unless stated.)
- Reset/idle: rst=1 for 3 cycles with enable=0 -> digit_en=0, seg=0, wr_ready=1, frame_done=0 throughout; no change for 50 cycles after rst=0.
- Basic scan: write 16'h4321, then enable=1 -> digit_en walks 0001,0000,0010,0000,0100,0000,1000,0000. Each strobe lasts 8 cycles, each gap 4 cycles. seg equals the decoder output for 1,2,3,4. frame_done pulses every 48 cycles.
- Tear-free update: write 16'h9999 mid-frame -> wr_ready=0 until the next frame start; the rest of the frame still shows 4321; the next frame shows 9999; wr_ready returns to 1 one cycle after the commit.
- Back-pressure: hold wr_valid=1 with changing data while pending is full -> no transfer; the word present on the cycle wr_ready rises is the one committed next.
- Leading zeros and bad BCD: LZ_BLANK=1, word 16'h0050 -> digits 3 and 2 are never strobed; digits 1 and 0 show 5 and 0. Word 16'h00A1 -> bcd_err=1 and stays set; the digit-1 slot has seg=0.
- Enable drop / reset mid-frame: enable=0 during digit 2 SHOW -> digit_en=0 on the next edge; re-enable restarts at digit 0. rst=1 mid-BLANK -> all reset values on the next edge; the pending word is lost.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller and its decoder.
//   SEG_OFF       : segment pattern with every segment dark
//   BCD_MAX       : largest legal BCD nibble value
//   scan_state_e  : scan FSM state encoding
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShow  = 2'd1,
        StBlank = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD to seven-segment decoder for common-cathode digits (active-high segments).
//   bin : BCD input nibble
//   seg : segments {g,f,e,d,c,b,a}; values above 9 give all segments off
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bin)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0000111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller sharing one decoder across NUM_DIGITS digits.
// A word accepted through the valid/ready port waits in a pending buffer and is
// committed to the displayed shadow word only at a frame start, so frames never tear.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : 1 = scanning, 0 = display off
//   wr_valid   : new display word offered on wr_data (packed BCD, digit 0 in bits 3:0)
//   wr_ready   : pending buffer empty
//   digit_en   : one-hot digit strobe
//   seg        : decoded segments, dark while no digit is strobed
//   frame_done : one-cycle pulse on the last cycle of a frame
//   bcd_err    : sticky flag, an accepted word held a nibble above 9
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned ON_TICKS    = 4,
    parameter int unsigned BLANK_TICKS = 1,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    wr_valid,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic                    wr_ready,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    frame_done,
    output logic                    bcd_err
);

    localparam int unsigned IdxW     = $clog2(NUM_DIGITS);
    localparam int unsigned PreW     = $clog2(TICK_DIV);
    localparam int unsigned MaxTicks = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int unsigned TickW    = $clog2(MaxTicks + 1);

    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_DIGITS - 1);
    localparam logic [PreW-1:0]  PreLast  = PreW'(TICK_DIV - 1);
    localparam logic [TickW-1:0] OnLast   = TickW'(ON_TICKS - 1);
    localparam logic [TickW-1:0] BlankLast = TickW'(BLANK_TICKS - 1);

    scan_state_e             state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [TickW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [PreW-1:0]         presc_q, presc_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic                    bcd_err_q, bcd_err_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [3:0]              bin_q, bin_d;

    logic                    tick;
    logic                    frame_start;
    logic                    bad_word;
    logic [NUM_DIGITS-1:0]   visible;
    logic [6:0]              dec_seg;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            tick_cnt_q  <= '0;
            presc_q     <= '0;
            shadow_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            bcd_err_q   <= 1'b0;
            digit_en_q  <= '0;
            bin_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_cnt_q  <= tick_cnt_d;
            presc_q     <= presc_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            bcd_err_q   <= bcd_err_d;
            digit_en_q  <= digit_en_d;
            bin_q       <= bin_d;
        end
    end

    // Next-state logic: prescaler, FSM, digit index and tick counting.
    always_comb begin
        tick        = (state_q != StIdle) && (presc_q == PreLast);
        state_d     = state_q;
        idx_d       = idx_q;
        tick_cnt_d  = tick_cnt_q;
        presc_d     = presc_q;
        frame_start = 1'b0;

        if (state_q != StIdle) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (!enable) begin
            state_d    = StIdle;
            idx_d      = '0;
            tick_cnt_d = '0;
            presc_d    = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d     = StShow;
                    idx_d       = '0;
                    tick_cnt_d  = '0;
                    presc_d     = '0;
                    frame_start = 1'b1;
                end
                StShow: begin
                    if (tick) begin
                        if (tick_cnt_q == OnLast) begin
                            state_d    = StBlank;
                            tick_cnt_d = '0;
                        end else begin
                            tick_cnt_d = tick_cnt_q + 1'b1;
                        end
                    end
                end
                StBlank: begin
                    if (tick) begin
                        if (tick_cnt_q == BlankLast) begin
                            state_d    = StShow;
                            tick_cnt_d = '0;
                            if (idx_q == LastIdx) begin
                                idx_d       = '0;
                                frame_start = 1'b1;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = StIdle;
                    idx_d      = '0;
                    tick_cnt_d = '0;
                    presc_d    = '0;
                end
            endcase
        end
    end

    // Handshake, commit and registered-output next values.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shadow_d    = shadow_q;
        bcd_err_d   = bcd_err_q;

        bad_word = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (wr_data[4*i +: 4] > BCD_MAX) begin
                bad_word = 1'b1;
            end
        end

        // Commit needs a full buffer and a transfer needs an empty one, so they never collide.
        if (frame_start && pend_full_q) begin
            shadow_d    = pend_q;
            pend_full_d = 1'b0;
        end
        if (wr_valid && !pend_full_q) begin
            pend_d      = wr_data;
            pend_full_d = 1'b1;
            if (bad_word) begin
                bcd_err_d = 1'b1;
            end
        end

        // A digit above 0 is dark when it and every higher digit are zero.
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            visible[i] = (i == 0) || !LZ_BLANK || ((shadow_d >> (4 * i)) != '0);
        end

        digit_en_d = '0;
        if ((state_d == StShow) && visible[idx_d]) begin
            digit_en_d[idx_d] = 1'b1;
        end
        bin_d = shadow_d[4*idx_d +: 4];
    end

    seven_seg_decoder u_dec (
        .bin (bin_q),
        .seg (dec_seg)
    );

    // Outputs.
    always_comb begin
        wr_ready   = !pend_full_q;
        digit_en   = digit_en_q;
        seg        = (digit_en_q != '0) ? dec_seg : SEG_OFF;
        frame_done = (state_q == StBlank) && tick && (tick_cnt_q == BlankLast) &&
                     (idx_q == LastIdx);
        bcd_err    = bcd_err_q;
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: two instances (leading-zero blanking off/on) share the
// same stimulus and are compared every cycle against a frame-time reference model.
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int ON    = 2;
    localparam int BL    = 1;
    localparam int SLOT  = (ON + BL) * DIV;
    localparam int FRAME = N * SLOT;
    localparam int ONCYC = ON * DIV;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           wr_valid = 1'b0;
    logic [4*N-1:0] wr_data = '0;

    logic           rdy0, rdy1, fd0, fd1, err0, err1;
    logic [N-1:0]   den0, den1;
    logic [6:0]     seg0, seg1;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (N), .TICK_DIV (DIV), .ON_TICKS (ON), .BLANK_TICKS (BL), .LZ_BLANK (1'b0)
    ) u_dut0 (
        .clk (clk), .rst (rst), .enable (enable), .wr_valid (wr_valid), .wr_data (wr_data),
        .wr_ready (rdy0), .digit_en (den0), .seg (seg0), .frame_done (fd0), .bcd_err (err0)
    );

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (N), .TICK_DIV (DIV), .ON_TICKS (ON), .BLANK_TICKS (BL), .LZ_BLANK (1'b1)
    ) u_dut1 (
        .clk (clk), .rst (rst), .enable (enable), .wr_valid (wr_valid), .wr_data (wr_data),
        .wr_ready (rdy1), .digit_en (den1), .seg (seg1), .frame_done (fd1), .bcd_err (err1)
    );

    // Reference model: m_t is the cycle position inside the current frame.
    bit          m_run = 1'b0;
    int          m_t = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_pend = '0;
    bit          m_full = 1'b0;
    bit          m_err = 1'b0;

    int n_pass = 0;
    int n_fail = 0;
    int n_checks = 0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic bit has_bad(input logic [15:0] w);
        for (int i = 0; i < N; i++) begin
            if (((w >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] exp_den(input bit lz);
        logic [N-1:0] r;
        int slot;
        r = '0;
        slot = m_t / SLOT;
        if (m_run && ((m_t % SLOT) < ONCYC)) begin
            if (!lz || slot == 0 || ((m_shadow >> (4 * slot)) != 16'h0)) r[slot] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [N-1:0] den);
        logic [15:0] w;
        w = m_shadow >> (4 * (m_t / SLOT));
        if (den == '0) return 7'h00;
        return seg_of(w[3:0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge: advance the model from the pre-edge inputs, then compare.
    task automatic step();
        bit xfer, commit;
        logic [N-1:0] e0, e1;
        bit fd_e;
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_t = 0; m_shadow = '0; m_full = 1'b0; m_err = 1'b0;
        end else begin
            xfer = wr_valid && !m_full;
            commit = 1'b0;
            if (!enable) begin
                m_run = 1'b0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_t = 0; commit = 1'b1;
            end else begin
                m_t = (m_t + 1) % FRAME;
                commit = (m_t == 0);
            end
            if (commit && m_full) begin
                m_shadow = m_pend; m_full = 1'b0;
            end
            if (xfer) begin
                m_pend = wr_data; m_full = 1'b1;
                if (has_bad(wr_data)) m_err = 1'b1;
            end
        end
        #1;
        e0 = exp_den(1'b0);
        e1 = exp_den(1'b1);
        fd_e = m_run && (m_t == FRAME - 1);
        chk("digit_en_lz0", 32'(den0), 32'(e0));
        chk("digit_en_lz1", 32'(den1), 32'(e1));
        chk("seg_lz0", 32'(seg0), 32'(exp_seg(e0)));
        chk("seg_lz1", 32'(seg1), 32'(exp_seg(e1)));
        chk("wr_ready", 32'({rdy0, rdy1}), 32'({!m_full, !m_full}));
        chk("frame_done", 32'({fd0, fd1}), 32'({fd_e, fd_e}));
        chk("bcd_err", 32'({err0, err1}), 32'({m_err, m_err}));
    endtask

    task automatic write_word(input logic [15:0] w);
        for (int i = 0; i < 200 && !rdy0; i++) step();
        wr_valid = 1'b1;
        wr_data  = w;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        for (int i = 0; i < 3 * FRAME && !(m_run && m_t == pos); i++) step();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            w = w << 4;
            if ($urandom_range(0, 2) == 0) w[3:0] = 4'd0;
            else w[3:0] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 15) == 0) w = 16'($urandom);
        return w;
    endfunction

    initial begin
        // Reset and idle.
        repeat (3) step();
        rst = 1'b0;
        repeat (50) step();

        // Basic scan of 4321.
        write_word(16'h4321);
        repeat (3) step();
        enable = 1'b1;
        repeat (2 * FRAME) step();

        // Tear-free update mid-frame.
        wait_pos(15);
        write_word(16'h9999);
        chk("pending_blocks_ready", 32'(rdy0), 32'd0);
        repeat (2 * FRAME) step();

        // Back-pressure: data keeps changing while the buffer is full.
        write_word(16'h5678);
        wr_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            wr_data = rand_word();
            step();
        end
        wr_valid = 1'b0;
        repeat (FRAME + 10) step();

        // Leading zeros, then an illegal nibble.
        write_word(16'h0050);
        repeat (2 * FRAME + 10) step();
        write_word(16'h00A1);
        repeat (2 * FRAME + 10) step();
        chk("bcd_err_sticky", 32'(err1), 32'd1);

        // Enable drop during the digit-2 strobe.
        wait_pos(2 * SLOT + 2);
        chk("digit2_strobe", 32'(den0), 32'h4);
        enable = 1'b0;
        step();
        chk("enable_drop_dark", 32'(den0), 32'h0);
        repeat (5) step();
        enable = 1'b1;
        step();
        chk("restart_digit0", 32'(den0), 32'h1);

        // Reset in the middle of a blanking gap discards the pending word.
        wait_pos(2);
        write_word(16'h8642);
        wait_pos(SLOT + ONCYC + 1);
        chk("pending_before_rst", 32'(rdy0), 32'd0);
        rst = 1'b1;
        step();
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_digit_en", 32'(den0), 32'h0);
        rst = 1'b0;
        repeat (FRAME + 5) step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            wr_valid = ($urandom_range(0, 7) == 0);
            wr_data  = rand_word();
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        wr_valid = 1'b0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
